mul_seq32: RTL and testbench



---
 rtl/mul_seq32_pkg.sv | 37 +++
 rtl/mul_ctrl.sv | 83 ++++++++
 rtl/mul_seq32.sv | 114 +++++++++++
 tb/tb_mul_seq32.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_seq32_pkg.sv
// Shared definitions for the sequential 32x32->64 multiplier.
// Holds the FSM state encoding, the iteration count and the 32-bit
// carry-lookahead adder used by the datapath.
package mul_seq32_pkg;

  localparam int unsigned OP_W   = 32;
  localparam int unsigned PROD_W = 64;
  localparam int unsigned CNT_W  = 5;

  typedef enum logic [1:0] {
    MS_IDLE = 2'd0,
    MS_BUSY = 2'd1,
    MS_FIX  = 2'd2,
    MS_DONE = 2'd3
  } ms_state_e;

  // Counter value of the final shift-add iteration.
  localparam logic [CNT_W-1:0] ITER_LAST = CNT_W'(31);

  // 32-bit carry-lookahead adder; result is {carry_out, sum}.
  function automatic logic [OP_W:0] cla32(input logic [OP_W-1:0] a,
                                          input logic [OP_W-1:0] b,
                                          input logic            cin);
    logic [OP_W-1:0] g;
    logic [OP_W-1:0] p;
    logic [OP_W:0]   c;
    g    = a & b;
    p    = a ^ b;
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < int'(OP_W); i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
    end
    return {c[OP_W], p ^ c[OP_W-1:0]};
  endfunction

endpackage

// File: rtl/mul_ctrl.sv
// Control FSM for mul_seq32: sequences IDLE -> BUSY (32 iterations) -> FIX
// -> DONE and back, with flush taking priority in every state.
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   flush              synchronous abort
//   in_valid           request from operand read
//   out_ready          writeback consumes the result
//   ready_c            request can be accepted this cycle (depends on flush)
//   load_c             operands are latched on this edge
//   busy, fix, done    state decodes driving the datapath and out_valid
module mul_ctrl
  import mul_seq32_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic flush,
  input  logic in_valid,
  input  logic out_ready,
  output logic ready_c,
  output logic load_c,
  output logic busy,
  output logic fix,
  output logic done
);

  ms_state_e        state;
  ms_state_e        state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;

  // State and iteration counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= MS_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state and control decode.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ready_c   = 1'b0;
    load_c    = 1'b0;
    busy      = 1'b0;
    fix       = 1'b0;
    done      = 1'b0;
    unique case (state)
      MS_IDLE: begin
        ready_c = !flush;
        if (in_valid && !flush) begin
          load_c    = 1'b1;
          cnt_nxt   = '0;
          state_nxt = MS_BUSY;
        end
      end
      MS_BUSY: begin
        busy    = 1'b1;
        cnt_nxt = cnt + CNT_W'(1);
        if (flush) begin
          state_nxt = MS_IDLE;
        end else if (cnt == ITER_LAST) begin
          state_nxt = MS_FIX;
        end
      end
      MS_FIX: begin
        fix       = 1'b1;
        state_nxt = flush ? MS_IDLE : MS_DONE;
      end
      MS_DONE: begin
        done = 1'b1;
        if (flush || out_ready) begin
          state_nxt = MS_IDLE;
        end
      end
      default: state_nxt = MS_IDLE;
    endcase
  end

endmodule

// File: rtl/mul_seq32.sv
// Multi-cycle 32x32->64 multiplier (MUL/IMUL) using radix-2 shift-add on
// operand magnitudes followed by a single sign-fix cycle.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   flush                 synchronous abort; discards any operation
//   in_valid/in_ready     request handshake; in_signed selects IMUL
//   in_a, in_b            multiplicand, multiplier
//   out_valid/out_ready   result handshake
//   out_prod              {EDX,EAX} product
//   out_cf, out_of        overflow flags (identical)
module mul_seq32
  import mul_seq32_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_signed,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out_prod,
  output logic                 out_cf,
  output logic                 out_of
);

  logic              ready_c;
  logic              load_c;
  logic              busy;
  logic              fix;
  logic              done;

  logic [OP_W-1:0]   mcand_q;
  logic [PROD_W-1:0] prod_q;
  logic              neg_q;
  logic              sgn_q;
  logic              cf_q;

  logic [OP_W-1:0]   mag_a_c;
  logic [OP_W-1:0]   mag_b_c;
  logic [OP_W:0]     sum_c;
  logic [OP_W:0]     neg_lo_c;
  logic [OP_W-1:0]   neg_hi_c;
  logic [PROD_W-1:0] fixed_c;
  logic              cf_c;

  mul_ctrl u_ctrl (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .out_ready (out_ready),
    .ready_c   (ready_c),
    .load_c    (load_c),
    .busy      (busy),
    .fix       (fix),
    .done      (done)
  );

  // Operand magnitudes; 0x80000000 negates to itself and is read as unsigned.
  always_comb begin
    mag_a_c = in_a;
    mag_b_c = in_b;
    if (in_signed && in_a[OP_W-1]) mag_a_c = OP_W'(cla32(~in_a, '0, 1'b1));
    if (in_signed && in_b[OP_W-1]) mag_b_c = OP_W'(cla32(~in_b, '0, 1'b1));
  end

  // One shift-add step: 33-bit partial sum keeps the carry for the shift.
  always_comb begin
    sum_c = {1'b0, prod_q[PROD_W-1:OP_W]};
    if (prod_q[0]) sum_c = cla32(prod_q[PROD_W-1:OP_W], mcand_q, 1'b0);
  end

  // Sign fix: invert and add one across two chained 32-bit adders.
  always_comb begin
    neg_lo_c = cla32(~prod_q[OP_W-1:0], '0, 1'b1);
    neg_hi_c = OP_W'(cla32(~prod_q[PROD_W-1:OP_W], '0, neg_lo_c[OP_W]));
    fixed_c  = neg_q ? {neg_hi_c, neg_lo_c[OP_W-1:0]} : prod_q;
    if (sgn_q) cf_c = fixed_c[PROD_W-1:OP_W] != {OP_W{fixed_c[OP_W-1]}};
    else       cf_c = fixed_c[PROD_W-1:OP_W] != '0;
  end

  // Datapath registers; {acc_hi, multiplier} share prod_q and shift together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q <= '0;
      prod_q  <= '0;
      neg_q   <= 1'b0;
      sgn_q   <= 1'b0;
      cf_q    <= 1'b0;
    end else if (load_c) begin
      mcand_q <= mag_a_c;
      prod_q  <= {{OP_W{1'b0}}, mag_b_c};
      neg_q   <= in_signed & (in_a[OP_W-1] ^ in_b[OP_W-1]);
      sgn_q   <= in_signed;
    end else if (busy) begin
      prod_q  <= {sum_c, prod_q[OP_W-1:1]};
    end else if (fix) begin
      prod_q  <= fixed_c;
      cf_q    <= cf_c;
    end
  end

  assign in_ready  = ready_c;
  assign out_valid = done;
  assign out_prod  = prod_q;
  assign out_cf    = cf_q;
  assign out_of    = cf_q;

endmodule

// File: tb/tb_mul_seq32.sv
// Self-checking bench for mul_seq32: directed corner cases, flush and
// asynchronous reset scenarios, and randomized operations compared each
// cycle against a latency-level behavioural model.
module tb_mul_seq32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_signed = 1'b0;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_prod;
  logic        out_cf;
  logic        out_of;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mul_seq32 #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_signed (in_signed),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_prod  (out_prod),
    .out_cf    (out_cf),
    .out_of    (out_of)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference product and flag from plain 64-bit arithmetic.
  function automatic logic [64:0] ref_mul(input logic s, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [63:0] xa;
    logic [63:0] xb;
    logic [63:0] p;
    logic        cf;
    xa = s ? {{32{a[31]}}, a} : {32'h0, a};
    xb = s ? {{32{b[31]}}, b} : {32'h0, b};
    p  = xa * xb;
    cf = s ? (p[63:32] != {32{p[31]}}) : (p[63:32] != 32'h0);
    return {cf, p};
  endfunction

  // Behavioural model: an accepted op yields its result 33 edges later and
  // holds it until consumed; flush or reset discard everything.
  logic        m_pending;
  logic        m_valid;
  int          m_lat;
  logic [63:0] m_prod;
  logic        m_cf;
  logic        m_ready;

  assign m_ready = !m_pending && !m_valid && !flush;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pending <= 1'b0;
      m_valid   <= 1'b0;
      m_lat     <= 0;
    end else if (flush) begin
      m_pending <= 1'b0;
      m_valid   <= 1'b0;
    end else if (!m_pending && !m_valid) begin
      if (in_valid) begin
        m_pending      <= 1'b1;
        m_lat          <= 33;
        {m_cf, m_prod} <= ref_mul(in_signed, in_a, in_b);
      end
    end else if (m_pending) begin
      m_lat <= m_lat - 1;
      if (m_lat == 1) begin
        m_pending <= 1'b0;
        m_valid   <= 1'b1;
      end
    end else if (out_ready) begin
      m_valid <= 1'b0;
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("in_ready", 64'(in_ready), 64'(m_ready));
      chk("out_valid", 64'(out_valid), 64'(m_valid));
      if (m_valid) begin
        chk("model prod", out_prod, m_prod);
        chk("model cf", 64'(out_cf), 64'(m_cf));
        chk("model of", 64'(out_of), 64'(m_cf));
      end
    end
  end

  // Present a request and return just after the accept edge.
  task automatic issue(input logic s, input logic [31:0] a, input logic [31:0] b);
    bit ok;
    ok = 1'b0;
    @(negedge clk);
    in_signed = s;
    in_a      = a;
    in_b      = b;
    in_valid  = 1'b1;
    for (int k = 0; k < 100; k++) begin
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) chk("accept timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_a     = $urandom;
    in_b     = $urandom;
  endtask

  // Wait for out_valid, toggling ignored inputs meanwhile; ends at a negedge.
  task automatic wait_valid(output int lat);
    lat = -1;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid) begin
        lat       = k;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        break;
      end
      out_ready = 1'($urandom);
      in_valid  = 1'($urandom);
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    if (lat < 0) chk("valid timeout", 64'd0, 64'd1);
  endtask

  task automatic run_op(input logic s, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp_prod, input logic exp_cf, input int hold);
    int          lat;
    logic [63:0] held;
    issue(s, a, b);
    wait_valid(lat);
    chk("latency", 64'(lat), 64'd33);
    chk("prod", out_prod, exp_prod);
    chk("cf", 64'(out_cf), 64'(exp_cf));
    chk("of", 64'(out_of), 64'(exp_cf));
    held = out_prod;
    for (int k = 0; k < hold; k++) @(negedge clk);
    if (hold > 0) begin
      chk("held valid", 64'(out_valid), 64'd1);
      chk("held prod", out_prod, held);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk("ready after handshake", 64'(in_ready), 64'd1);
    chk("valid after handshake", 64'(out_valid), 64'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " valid"}, 64'(out_valid), 64'd0);
    chk({tag, " ready"}, 64'(in_ready), 64'd1);
    chk({tag, " prod"}, out_prod, 64'd0);
    chk({tag, " cf"}, 64'(out_cf), 64'd0);
    chk({tag, " of"}, 64'(out_of), 64'd0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [64:0] r;
    logic        s;
    logic [31:0] a;
    logic [31:0] b;
    int          lat;

    #8;
    chk_reset_outputs("reset");
    #4;
    rst_n = 1'b1;

    // Directed corner cases.
    run_op(1'b0, 32'd7, 32'd6, 64'h0000_0000_0000_002A, 1'b0, 0);
    run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b1, 0);
    run_op(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001, 1'b0, 0);
    run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 1'b1, 0);
    // Backpressure then an immediate second op.
    run_op(1'b1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 1'b1, 10);
    run_op(1'b1, 32'hFFFF_FFF9, 32'd6, 64'hFFFF_FFFF_FFFF_FFD6, 1'b0, 0);

    // Flush during iteration 15.
    issue(1'b0, 32'd100, 32'd200);
    repeat (15) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    @(negedge clk);
    chk("flush busy ready", 64'(in_ready), 64'd1);
    chk("flush busy valid", 64'(out_valid), 64'd0);
    repeat (40) @(negedge clk);
    chk("flush busy no result", 64'(out_valid), 64'd0);
    run_op(1'b0, 32'd3, 32'd5, 64'd15, 1'b0, 0);

    // Flush and in_valid together in IDLE: no accept.
    @(posedge clk);
    #1;
    flush     = 1'b1;
    in_valid  = 1'b1;
    in_signed = 1'b0;
    in_a      = 32'd9;
    in_b      = 32'd9;
    @(negedge clk);
    chk("flush idle ready low", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    repeat (36) @(negedge clk);
    chk("flush idle no op", 64'(out_valid), 64'd0);

    // Flush together with out_ready in DONE.
    issue(1'b0, 32'd11, 32'd13);
    wait_valid(lat);
    chk("flush done latency", 64'(lat), 64'd33);
    @(posedge clk);
    #1;
    flush     = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    flush     = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    chk("flush done valid", 64'(out_valid), 64'd0);
    chk("flush done ready", 64'(in_ready), 64'd1);

    // Asynchronous reset mid-BUSY.
    issue(1'b1, 32'h1234_5678, 32'hFEDC_BA98);
    repeat (10) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("rst busy");
    #1;
    rst_n = 1'b1;
    r = ref_mul(1'b1, 32'hDEAD_BEEF, 32'h0000_1234);
    run_op(1'b1, 32'hDEAD_BEEF, 32'h0000_1234, r[63:0], r[64], 0);

    // Asynchronous reset in DONE.
    issue(1'b0, 32'hCAFE_F00D, 32'h0BAD_F00D);
    wait_valid(lat);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("rst done");
    #1;
    rst_n = 1'b1;
    r = ref_mul(1'b0, 32'h0001_0000, 32'h0001_0000);
    run_op(1'b0, 32'h0001_0000, 32'h0001_0000, r[63:0], r[64], 1);

    // Randomized operations.
    for (int n = 0; n < 30; n++) begin
      s = 1'($urandom);
      a = pick();
      b = pick();
      r = ref_mul(s, a, b);
      run_op(s, a, b, r[63:0], r[64], int'($urandom_range(0, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
